// File: rtl/top_k_pkg.sv
// Shared constants and state encoding for the top-k input unpacker.
package top_k_pkg;

  localparam int INTEGER_SIZE = 32;
  localparam int DATA_WIDTH   = 512;
  localparam int LANES        = DATA_WIDTH / INTEGER_SIZE;
  localparam int KEEP_W       = DATA_WIDTH / 8;
  localparam int CNT_BITS     = 32;
  localparam int SEL_W        = $clog2(LANES);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/top_k_lane_sel.sv
// Lowest-set-lane picker over the pending-lane mask of the holding register.
module top_k_lane_sel
  import top_k_pkg::*;
(
  input  logic [LANES-1:0] mask,
  output logic [SEL_W-1:0] sel,
  output logic             any,
  output logic             one_left
);

  logic [LANES-1:0] mask_m1;

  // Priority search from the top down so the lowest set index wins.
  always_comb begin
    sel     = '0;
    mask_m1 = mask - {{(LANES-1){1'b0}}, 1'b1};
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) sel = SEL_W'(i);
    end
    any      = |mask;
    // Clearing the lowest set bit leaves nothing exactly when one bit is set.
    one_left = any && ((mask & mask_m1) == '0);
  end

endmodule

// File: rtl/top_k_unpacker.sv
// Serialises 512-bit stream words into 32-bit integers and frames them into
// batches of batch_len integers with a generated TLAST.
//
// Handshakes on both ports: a beat transfers on a rising clk edge where
// TVALID and TREADY are both high; a raised TVALID holds its data stable
// until that transfer, except when clear or rst flushes the datapath.
module top_k_unpacker
  import top_k_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    s_axis_TVALID,
  output logic                    s_axis_TREADY,
  input  logic [DATA_WIDTH-1:0]   s_axis_TDATA,
  input  logic [KEEP_W-1:0]       s_axis_TKEEP,
  input  logic                    s_axis_TLAST,
  input  logic [CNT_BITS-1:0]     batch_len,
  output logic                    m_axis_TVALID,
  input  logic                    m_axis_TREADY,
  output logic [INTEGER_SIZE-1:0] m_axis_TDATA,
  output logic                    m_axis_TLAST,
  output logic [CNT_BITS-1:0]     batches_done,
  output logic                    keep_err
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [LANES-1:0]      mask_q, mask_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [CNT_BITS-1:0]   len_q, len_d;
  logic [CNT_BITS-1:0]   batches_q, batches_d;
  logic                  keep_err_q, keep_err_d;

  logic [SEL_W-1:0]      sel;
  logic                  any_left;
  logic                  one_left;
  logic [LANES-1:0]      lane_mask;
  logic                  lane_partial;
  logic [CNT_BITS-1:0]   live_len;
  logic [CNT_BITS-1:0]   eff_len;
  logic                  in_hs;
  logic                  out_hs;

  top_k_lane_sel u_lane_sel (
    .mask     (mask_q),
    .sel      (sel),
    .any      (any_left),
    .one_left (one_left)
  );

  // Segment boundaries from TCP carry no batch meaning.
  logic unused_tlast;
  assign unused_tlast = s_axis_TLAST ^ any_left;

  // State and datapath registers; rst abandons any partial batch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      hold_q     <= '0;
      mask_q     <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      batches_q  <= '0;
      keep_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      mask_q     <= mask_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      batches_q  <= batches_d;
      keep_err_q <= keep_err_d;
    end
  end

  // Output decode: current lane, batch framing and input backpressure.
  always_comb begin
    live_len      = (batch_len == '0) ? CNT_BITS'(1) : batch_len;
    eff_len       = (cnt_q == '0) ? live_len : len_q;
    m_axis_TVALID = (state_q == ST_DRAIN);
    m_axis_TDATA  = hold_q[int'(sel) * INTEGER_SIZE +: INTEGER_SIZE];
    m_axis_TLAST  = m_axis_TVALID && (cnt_q == eff_len - CNT_BITS'(1));
    out_hs        = m_axis_TVALID && m_axis_TREADY;
    // Reload while the final lane leaves, so full words stream bubble-free.
    s_axis_TREADY = !rst && !clear &&
                    ((state_q == ST_EMPTY) || (out_hs && one_left));
    in_hs         = s_axis_TVALID && s_axis_TREADY;
    batches_done  = batches_q;
    keep_err      = keep_err_q;
  end

  // Lane qualification: only fully-kept lanes carry an integer.
  always_comb begin
    lane_mask    = '0;
    lane_partial = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      lane_mask[k] = &s_axis_TKEEP[4*k +: 4];
      if ((|s_axis_TKEEP[4*k +: 4]) && !(&s_axis_TKEEP[4*k +: 4])) lane_partial = 1'b1;
    end
  end

  // Next-state: drain lanes, count batches, load words; clear overrides all.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    mask_d     = mask_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    batches_d  = batches_q;
    keep_err_d = 1'b0;
    if (clear) begin
      state_d = ST_EMPTY;
      mask_d  = '0;
      cnt_d   = '0;
    end else begin
      if (out_hs) begin
        mask_d[sel] = 1'b0;
        if (one_left) state_d = ST_EMPTY;
        // Length is frozen at the first integer so mid-batch edits wait.
        if (cnt_q == '0) len_d = live_len;
        cnt_d = m_axis_TLAST ? '0 : cnt_q + CNT_BITS'(1);
        if (m_axis_TLAST) batches_d = batches_q + CNT_BITS'(1);
      end
      if (in_hs) begin
        hold_d     = s_axis_TDATA;
        mask_d     = lane_mask;
        state_d    = (lane_mask != '0) ? ST_DRAIN : ST_EMPTY;
        keep_err_d = lane_partial;
      end
    end
  end

endmodule

// File: tb/tb_top_k_unpacker.sv
// Directed bench for top_k_unpacker: hand-computed integer/TLAST sequences.
module tb_top_k_unpacker;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         s_valid;
  logic         s_ready;
  logic [511:0] s_data;
  logic [63:0]  s_keep;
  logic         s_last;
  logic [31:0]  batch_len;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic [31:0]  batches_done;
  logic         keep_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected beats: {tlast, data}.
  logic [32:0] exp_q[$];

  top_k_unpacker dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .s_axis_TVALID (s_valid),
    .s_axis_TREADY (s_ready),
    .s_axis_TDATA  (s_data),
    .s_axis_TKEEP  (s_keep),
    .s_axis_TLAST  (s_last),
    .batch_len     (batch_len),
    .m_axis_TVALID (m_valid),
    .m_axis_TREADY (m_ready),
    .m_axis_TDATA  (m_data),
    .m_axis_TLAST  (m_last),
    .batches_done  (batches_done),
    .keep_err      (keep_err)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_word(input int base);
    logic [511:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) w[32*k +: 32] = 32'(base + k);
    return w;
  endfunction

  // Present a word and hold it until accepted (bounded).
  task automatic send_word(input logic [511:0] d, input logic [63:0] k);
    int waited;
    s_valid = 1'b1;
    s_data  = d;
    s_keep  = k;
    waited  = 0;
    @(negedge clk);
    while (!s_ready && waited < 100) begin
      step();
      @(negedge clk);
      waited++;
    end
    chk("s_ready_wait", 32'(s_ready), 32'd1);
    step();
    s_valid = 1'b0;
    s_keep  = '0;
  endtask

  task automatic push_run(input int base, input int n, input int last_mod);
    for (int i = 0; i < n; i++)
      exp_q.push_back({((i + 1) % last_mod) == 0, 32'(base + i)});
  endtask

  // Consume n beats; bp=1 applies the 1,0,0,1 ready pattern and checks stalls.
  task automatic drain(input int n, input bit bp);
    int          beats;
    int          c;
    logic        stalled;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [32:0] e;
    beats = 0; c = 0; stalled = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (beats < n && c < 500) begin
      if (bp) begin
        case (c % 4)
          1, 2:    m_ready = 1'b0;
          default: m_ready = 1'b1;
        endcase
      end else begin
        m_ready = 1'b1;
      end
      @(negedge clk);
      if (!bp) chk("no_bubble_valid", 32'(m_valid), 32'd1);
      if (m_valid && stalled) begin
        chk("stall_data", m_data, prev_data);
        chk("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h1_ffff_ffff;
        chk("beat_data", m_data, e[31:0]);
        chk("beat_last", 32'(m_last), 32'(e[32]));
        beats++;
      end
      stalled   = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
      step();
      c++;
    end
    chk("drain_beats", 32'(beats), 32'(n));
    m_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0;
    s_last = 1'b0; batch_len = 32'd16; m_ready = 1'b1;

    // Reset values
    repeat (3) step();
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_batches", batches_done, 32'd0);
    chk("rst_keep_err", 32'(keep_err), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);
    step();

    // Full-word batch: 1..16, TLAST on 16, s_axis_TLAST toggled to show no effect
    batch_len = 32'd16;
    s_last = 1'b1;
    send_word(mk_word(1), {64{1'b1}});
    s_last = 1'b0;
    push_run(1, 16, 16);
    drain(16, 1'b0);
    @(negedge clk);
    chk("full_idle_valid", 32'(m_valid), 32'd0);
    chk("full_batches", batches_done, 32'd1);
    step();

    // Cross-word batch of 20 over two back-to-back words
    batch_len = 32'd20;
    send_word(mk_word(100), {64{1'b1}});
    s_valid = 1'b1;
    s_data  = mk_word(200);
    s_keep  = {64{1'b1}};
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("cross_valid", 32'(m_valid), 32'd1);
      chk("cross_data", m_data, (i < 16) ? 32'(100 + i) : 32'(200 + i - 16));
      chk("cross_last", 32'(m_last), 32'(i == 19));
      if (i < 16) chk("cross_s_ready", 32'(s_ready), 32'(i == 15));
      step();
      if (i == 15) begin
        s_valid = 1'b0;
        s_keep  = '0;
      end
    end
    @(negedge clk);
    chk("cross_idle_valid", 32'(m_valid), 32'd0);
    chk("cross_cnt", dut.cnt_q, 32'd12);
    chk("cross_batches", batches_done, 32'd2);

    // clear with nothing in flight resets the partial count only
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("clear_cnt", dut.cnt_q, 32'd0);
    chk("clear_batches", batches_done, 32'd2);
    step();

    // Sparse keep: lanes 1 and 8 full, lane 2 partial
    batch_len = 32'd2;
    send_word(mk_word(300), 64'h0000_000F_0000_03F0);
    @(negedge clk);
    chk("sparse_keep_err", 32'(keep_err), 32'd1);
    chk("sparse_valid0", 32'(m_valid), 32'd1);
    chk("sparse_data0", m_data, 32'd301);
    chk("sparse_last0", 32'(m_last), 32'd0);
    step();
    @(negedge clk);
    chk("sparse_keep_err_off", 32'(keep_err), 32'd0);
    chk("sparse_data1", m_data, 32'd308);
    chk("sparse_last1", 32'(m_last), 32'd1);
    step();
    @(negedge clk);
    chk("sparse_idle_valid", 32'(m_valid), 32'd0);
    chk("sparse_batches", batches_done, 32'd3);
    step();

    // Backpressure with batch_len 4
    batch_len = 32'd4;
    send_word(mk_word(400), {64{1'b1}});
    push_run(400, 16, 4);
    drain(16, 1'b1);
    @(negedge clk);
    chk("bp_batches", batches_done, 32'd7);
    step();

    // batch_len 0 behaves as 1: TLAST on every integer (lanes 0..2)
    batch_len = 32'd0;
    send_word(mk_word(600), 64'h0000_0000_0000_0FFF);
    push_run(600, 3, 1);
    drain(3, 1'b0);
    @(negedge clk);
    chk("len0_batches", batches_done, 32'd10);
    step();

    // TKEEP = 0: accepted, dropped, no output
    send_word(mk_word(650), 64'h0);
    @(negedge clk);
    chk("keep0_valid", 32'(m_valid), 32'd0);
    chk("keep0_s_ready", 32'(s_ready), 32'd1);
    chk("keep0_batches", batches_done, 32'd10);
    step();

    // batch_len 5 -> 3 mid-batch: first batch ends at 5, next at 3
    batch_len = 32'd5;
    send_word(mk_word(700), 64'h0000_0000_FFFF_FFFF);
    exp_q.push_back({1'b0, 32'd700});
    exp_q.push_back({1'b0, 32'd701});
    drain(2, 1'b0);
    batch_len = 32'd3;
    exp_q.push_back({1'b0, 32'd702});
    exp_q.push_back({1'b0, 32'd703});
    exp_q.push_back({1'b1, 32'd704});
    exp_q.push_back({1'b0, 32'd705});
    exp_q.push_back({1'b0, 32'd706});
    exp_q.push_back({1'b1, 32'd707});
    drain(6, 1'b0);
    @(negedge clk);
    chk("lenchg_batches", batches_done, 32'd12);
    step();

    // clear at integer 7 of 16
    batch_len = 32'd16;
    send_word(mk_word(800), {64{1'b1}});
    push_run(800, 6, 16);
    drain(6, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    chk("clear_blocks_s_ready", 32'(s_ready), 32'd0);
    chk("clear_pre_valid", 32'(m_valid), 32'd1);
    chk("clear_pre_data", m_data, 32'd806);
    step();
    clear = 1'b0;
    @(negedge clk);
    chk("clear_valid", 32'(m_valid), 32'd0);
    chk("clear_mid_cnt", dut.cnt_q, 32'd0);
    chk("clear_mid_batches", batches_done, 32'd12);
    step();
    send_word(mk_word(900), {64{1'b1}});
    push_run(900, 16, 16);
    drain(16, 1'b0);
    @(negedge clk);
    chk("after_clear_batches", batches_done, 32'd13);
    step();

    // rst at integer 7 of 16
    send_word(mk_word(1000), {64{1'b1}});
    push_run(1000, 6, 16);
    drain(6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_s_ready", 32'(s_ready), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", 32'(m_valid), 32'd0);
    chk("rst_mid_batches", batches_done, 32'd0);
    chk("rst_mid_s_ready_back", 32'(s_ready), 32'd1);
    step();
    send_word(mk_word(1100), {64{1'b1}});
    push_run(1100, 16, 16);
    drain(16, 1'b0);
    @(negedge clk);
    chk("after_rst_batches", batches_done, 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
